algo_1r1w_sram_bank_resp: RTL

//  Responder end of the t1/t2 physical-bank interface driven by the algo_*_top memory cores.

---
 rtl/algo_1r1w_sram_bank_resp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/algo_1r1w_sram_bank_resp.sv
// rtl/algo_1r1w_sram_bank_resp.sv - 1W/1R SRAM bank responder with zero-init sweep (optional SRAM_COLLCHK_EN)
module algo_1r1w_sram_bank_resp #(
  parameter int PHYWDTH    = 132,
  parameter int NUMSROW    = 512,
  parameter int BITSROW    = 9,
  parameter int SRAM_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               writeA,
  input  logic [BITSROW-1:0] addrA,
  input  logic [PHYWDTH-1:0] dinA,
  input  logic [PHYWDTH-1:0] bwA,
  input  logic               readB,
  input  logic [BITSROW-1:0] addrB,
  output logic [PHYWDTH-1:0] doutB,
  output logic               coll_err
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [BITSROW:0]   ROWS     = (BITSROW+1)'(NUMSROW);
  localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);

  state_t               state;
  logic [BITSROW-1:0]   cnt;
  logic [PHYWDTH-1:0]   mem [NUMSROW];
  logic                 wr_ok;
  logic                 rd_fire;
  logic [PHYWDTH-1:0]   rd_data;
  logic                 last_vld;
  logic [PHYWDTH-1:0]   last_data;

  // Accesses only count once the sweep is done and reset is not being applied.
  assign wr_ok   = !rst && ready && writeA && ({1'b0, addrA} < ROWS);
  assign rd_fire = !rst && ready && readB;
  // Out-of-range rows read as zero; the array is sampled before this edge's write lands.
  assign rd_data = ({1'b0, addrB} < ROWS) ? mem[addrB] : '0;

  // Init sweep sequencer: counts rows 0..NUMSROW-1, then holds RUN with ready raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST_ROW) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single array write port shared by the zero sweep and bit-masked user writes.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[addrA] <= (mem[addrA] & ~bwA) | (dinA & bwA);
    end
  end

  generate
    if (SRAM_DELAY == 1) begin : g_direct
      assign last_vld  = rd_fire;
      assign last_data = rd_data;
    end else begin : g_pipe
      logic               vld_q  [SRAM_DELAY-1];
      logic [PHYWDTH-1:0] data_q [SRAM_DELAY-1];

      // Read shift pipeline; doutB itself is the final stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SRAM_DELAY - 1; i++) begin
            vld_q[i]  <= 1'b0;
            data_q[i] <= '0;
          end
        end else begin
          vld_q[0]  <= rd_fire;
          data_q[0] <= rd_data;
          for (int i = 1; i < SRAM_DELAY - 1; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
          end
        end
      end

      assign last_vld  = vld_q[SRAM_DELAY-2];
      assign last_data = data_q[SRAM_DELAY-2];
    end
  endgenerate

  // Output register: updates only when a read completes, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutB <= '0;
    end else if (last_vld) begin
      doutB <= last_data;
    end
  end

`ifdef SRAM_COLLCHK_EN
  // Sticky flag for same-row read/write with a non-empty bit mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_err <= 1'b0;
    end else if (ready && writeA && readB && (addrA == addrB) &&
                 ({1'b0, addrA} < ROWS) && (|bwA)) begin
      coll_err <= 1'b1;
`ifndef SYNTHESIS
      $display("algo_1r1w_sram_bank_resp: read/write collision on row %0d at time %0t", addrA, $time);
`endif
    end
  end
`else
  assign coll_err = 1'b0;
`endif

endmodule
